// File: rtl/spd_pkg.sv
// Shared types, defaults and trellis helpers for the 4-state survivor-path decoder.
package spd_pkg;

  localparam int NUM_STATES = 4;
  localparam int DEPTH_DEF  = 8;
  localparam int PM_W_DEF   = 4;

  // State s = {newest input bit, previous input bit}; the ACS decision picks the dropped bit.
  function automatic logic [1:0] prev_state(input logic [1:0] s, input logic d);
    return {s[0], d};
  endfunction

endpackage

// File: rtl/spd_min4.sv
// Combinational argmin over four unsigned path metrics; the lowest index wins ties.
module spd_min4 #(
  parameter int PM_W = 4
) (
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [PM_W-1:0] pm2,
  input  logic [PM_W-1:0] pm3,
  output logic [1:0]      best
);

  logic [1:0]      lo_idx_s;
  logic [1:0]      hi_idx_s;
  logic [PM_W-1:0] lo_pm_s;
  logic [PM_W-1:0] hi_pm_s;

  // Two-level tournament; strict less-than keeps the lower index on equal metrics.
  always_comb begin
    lo_idx_s = 2'd0;
    lo_pm_s  = pm0;
    hi_idx_s = 2'd2;
    hi_pm_s  = pm2;
    best     = 2'd0;
    if (pm1 < pm0) begin
      lo_idx_s = 2'd1;
      lo_pm_s  = pm1;
    end else begin
      lo_idx_s = 2'd0;
      lo_pm_s  = pm0;
    end
    if (pm3 < pm2) begin
      hi_idx_s = 2'd3;
      hi_pm_s  = pm3;
    end else begin
      hi_idx_s = 2'd2;
      hi_pm_s  = pm2;
    end
    if (hi_pm_s < lo_pm_s) begin
      best = hi_idx_s;
    end else begin
      best = lo_idx_s;
    end
  end

endmodule

// File: rtl/spd_unit.sv
// Register-exchange survivor memory for a K=3 Viterbi decoder; emits the bit DEPTH steps
// back on the survivor of the currently best-metric state.
module spd_unit
  import spd_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PM_W  = PM_W_DEF
) (
  input  logic            d0,
  input  logic            d1,
  input  logic            d2,
  input  logic            d3,
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [PM_W-1:0] pm2,
  input  logic [PM_W-1:0] pm3,
  output logic            out,
  input  logic            clk,
  input  logic            reset
);

  logic [NUM_STATES-1:0] dec_s;
  logic [1:0]            best_s;
  logic [1:0]            st_s;
  logic [DEPTH-1:0]      surv_r      [NUM_STATES];
  logic [DEPTH-1:0]      surv_next_s [NUM_STATES];

  assign dec_s = {d3, d2, d1, d0};

  spd_min4 #(
    .PM_W (PM_W)
  ) u_min4 (
    .pm0  (pm0),
    .pm1  (pm1),
    .pm2  (pm2),
    .pm3  (pm3),
    .best (best_s)
  );

  // Exchange step: each state inherits its predecessor's history and appends its own bit.
  always_comb begin
    st_s = 2'd0;
    for (int s = 0; s < NUM_STATES; s++) begin
      st_s           = 2'(s);
      surv_next_s[s] = {surv_r[prev_state(st_s, dec_s[s])][DEPTH-2:0], st_s[1]};
    end
  end

  // Survivor registers and decoded-bit register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        surv_r[s] <= {DEPTH{1'b0}};
      end
      out <= 1'b0;
    end else begin
      surv_r <= surv_next_s;
      out    <= surv_next_s[best_s][DEPTH-1];
    end
  end

endmodule

// File: tb/tb_spd_unit.sv
// Directed and random bench for spd_unit against a path-history model of the decoder.
module tb_spd_unit;

  localparam int DEPTH = 8;
  localparam int PM_W  = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            d0 = 1'b0, d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
  logic [PM_W-1:0] pm0 = '0, pm1 = '0, pm2 = '0, pm3 = '0;
  logic            out;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: hist[s][i] is the input bit decided i steps ago along state s's survivor.
  bit   hist [4][DEPTH];
  logic exp_out = 1'b0;
  bit   chk_en  = 1'b0;

  spd_unit #(.DEPTH(DEPTH), .PM_W(PM_W)) dut (
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .pm0(pm0), .pm1(pm1), .pm2(pm2), .pm3(pm3),
    .out(out), .clk(clk), .reset(reset)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at %0t: out=%b expected=%b", name, $time, act, expv);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) check("model", out, exp_out);
  end

  // One trellis step: drive inputs, advance the model, let the edge happen.
  task automatic step(input logic [3:0] dv, input logic [15:0] pmv, input logic rst);
    int  pm [4];
    int  best;
    int  p;
    bit  nh [4][DEPTH];
    logic e;
    {d3, d2, d1, d0} = dv;
    {pm3, pm2, pm1, pm0} = pmv;
    reset = rst;
    pm[0] = int'(pmv[3:0]);  pm[1] = int'(pmv[7:4]);
    pm[2] = int'(pmv[11:8]); pm[3] = int'(pmv[15:12]);
    if (rst) begin
      foreach (hist[s, i]) hist[s][i] = 1'b0;
      e = 1'b0;
    end else begin
      for (int s = 0; s < 4; s++) begin
        p = ((s % 2) * 2) + int'(dv[s]);
        nh[s][0] = bit'(s / 2);
        for (int i = 1; i < DEPTH; i++) nh[s][i] = hist[p][i-1];
      end
      best = 0;
      for (int s = 1; s < 4; s++) if (pm[s] < pm[best]) best = s;
      e = nh[best][DEPTH-1];
      hist = nh;
    end
    @(posedge clk);
    exp_out = e;
    chk_en  = 1'b1;
    #1;
  endtask

  localparam logic [3:0]  DPAT    = 4'b1010;                          // d0=0,d1=1,d2=0,d3=1
  localparam logic [15:0] PM_B2   = {4'd1, 4'd0, 4'd1, 4'd1};
  localparam logic [15:0] PM_B3   = {4'd0, 4'd1, 4'd1, 4'd1};
  localparam logic [15:0] PM_TIE  = {4'd5, 4'd5, 4'd5, 4'd5};
  localparam logic [15:0] PM_B0   = {4'd3, 4'd3, 4'd3, 4'd0};

  initial begin
    // Reset with arbitrary inputs, then best=2 whose survivor feeds only zeros.
    step(4'b1111, 16'h1234, 1'b1);
    check("reset_out", out, 1'b0);
    for (int s = 0; s < 4; s++) begin
      n_cmp++;
      if (dut.surv_r[s] !== 8'h00) begin
        n_bad++;
        $display("FAIL reset_surv%0d: got=%h expected=00", s, dut.surv_r[s]);
      end
    end
    for (int k = 1; k <= 30; k++) begin
      step(DPAT, PM_B2, 1'b0);
      check("best2_zero", out, 1'b0);
    end

    // Latency, then best-state switch to state 0.
    step(DPAT, PM_B3, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      step(DPAT, PM_B3, 1'b0);
      check("latency", out, (k >= DEPTH) ? 1'b1 : 1'b0);
    end
    for (int k = 1; k <= 5; k++) begin
      step(DPAT, PM_B0, 1'b0);
      check("switch_to0", out, 1'b0);
    end

    // Equal metrics resolve to state 0.
    step(DPAT, PM_TIE, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      step(DPAT, PM_TIE, 1'b0);
      check("tie_break", out, 1'b0);
    end

    // Mid-stream reset after the output has gone high.
    step(DPAT, PM_B3, 1'b1);
    for (int k = 1; k <= 10; k++) step(DPAT, PM_B3, 1'b0);
    check("pre_reset_high", out, 1'b1);
    step(DPAT, PM_B3, 1'b1);
    check("mid_reset", out, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(DPAT, PM_B3, 1'b0);
      check("post_reset_latency", out, (k >= DEPTH) ? 1'b1 : 1'b0);
    end

    // Random decisions and metrics with rare resets; checked by the per-cycle compare.
    for (int k = 0; k < 1000; k++) begin
      step(4'($urandom_range(0, 15)), 16'($urandom), ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
